// File: rtl/ddp_fetch_pkg.sv
// Shared types and default widths for the data-driven processor packet fetch path.
package ddp_fetch_pkg;

    localparam int DEF_PACKET_W  = 38;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_STOP_BIT  = 37;
    localparam int DEF_LAST_ADDR = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/packet_fetch_ctrl_if.sv
// Bundle of host control, packet memory and pipeline handshake signals around the fetch controller.
interface packet_fetch_ctrl_if #(
    parameter int PACKET_W = ddp_fetch_pkg::DEF_PACKET_W,
    parameter int ADDR_W   = ddp_fetch_pkg::DEF_ADDR_W
);

    logic                send_in;
    logic                pc_update;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_re;
    logic [PACKET_W-1:0] mem_data;
    logic [PACKET_W-1:0] packet_out;
    logic                packet_valid;
    logic                packet_ready;
    logic [ADDR_W-1:0]   pc_out;
    logic                busy;
    logic                done;

    // The fetch controller masters the memory port and the packet stream.
    modport master (
        input  send_in, pc_update, pc_next, mem_data, packet_ready,
        output mem_addr, mem_re, packet_out, packet_valid, pc_out, busy, done
    );

    modport slave (
        output send_in, pc_update, pc_next, mem_data, packet_ready,
        input  mem_addr, mem_re, packet_out, packet_valid, pc_out, busy, done
    );

endinterface

// File: rtl/fetch_pc_arb.sv
// Program counter with a pending-load slot; priority is new load > pending load > increment > hold.
module fetch_pc_arb
    import ddp_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idle,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              advance,
    input  logic              finish,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_nxt
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_val_q, pend_val_d;
    logic              pend_flag_q, pend_flag_d;

    // A load that lands on the handshake cycle beats any older pending value;
    // outside IDLE loads are parked so the packet in flight is not disturbed.
    always_comb begin
        pc_nxt      = pc_q;
        pend_val_d  = pend_val_q;
        pend_flag_d = pend_flag_q;
        if (advance || finish) begin
            pend_flag_d = 1'b0;
            if (load)
                pc_nxt = load_value;
            else if (pend_flag_q)
                pc_nxt = pend_val_q;
            else if (finish)
                pc_nxt = '0;
            else
                pc_nxt = pc_q + ADDR_W'(1);
        end else if (load) begin
            if (idle) begin
                pc_nxt = load_value;
            end else begin
                pend_val_d  = load_value;
                pend_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            pend_val_q  <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            pc_q        <= pc_nxt;
            pend_val_q  <= pend_val_d;
            pend_flag_q <= pend_flag_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/packet_fetch_ctrl.sv
// Packet fetch sequencer: reads program memory one packet at a time and hands each to the pipeline via valid/ready.
module packet_fetch_ctrl
    import ddp_fetch_pkg::*;
#(
    parameter int PACKET_W  = DEF_PACKET_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LAST_ADDR = DEF_LAST_ADDR,
    parameter int STOP_BIT  = DEF_STOP_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    packet_fetch_ctrl_if.master bus
);

    fetch_state_t        state_q, state_d;
    logic                send_q;
    logic                mem_re_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [PACKET_W-1:0] packet_q;
    logic                valid_q;
    logic                done_q;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_nxt;
    logic                send_rise;
    logic                handshake;
    logic                last_pkt;
    logic                advance;
    logic                finish;
    logic                idle;

    assign send_rise = bus.send_in & ~send_q;
    assign idle      = (state_q == IDLE);
    assign handshake = (state_q == HOLD) & bus.packet_ready;
    assign last_pkt  = packet_q[STOP_BIT] | (pc == ADDR_W'(LAST_ADDR));
    assign advance   = handshake & ~last_pkt;
    assign finish    = handshake & last_pkt;

    fetch_pc_arb #(
        .ADDR_W (ADDR_W)
    ) u_pc_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .idle       (idle),
        .load       (bus.pc_update),
        .load_value (bus.pc_next),
        .advance    (advance),
        .finish     (finish),
        .pc         (pc),
        .pc_nxt     (pc_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (send_rise) state_d = REQ;
            REQ:     state_d = CAP;
            CAP:     state_d = HOLD;
            HOLD:    if (handshake) state_d = finish ? IDLE : REQ;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so MEM_RE/VALID line up with REQ/HOLD
    // and MEM_ADDR always mirrors the PC, including a load taken on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            send_q     <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            packet_q   <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            send_q     <= bus.send_in;
            mem_re_q   <= (state_d == REQ);
            mem_addr_q <= pc_nxt;
            valid_q    <= (state_d == HOLD);
            done_q     <= finish;
            if (state_q == CAP)
                packet_q <= bus.mem_data;
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_re       = mem_re_q;
    assign bus.packet_out   = packet_q;
    assign bus.packet_valid = valid_q;
    assign bus.pc_out       = pc;
    assign bus.busy         = ~idle;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_packet_fetch_ctrl.sv
// Self-checking bench for packet_fetch_ctrl: directed scenarios plus randomized runs against a program-order model.
module tb_packet_fetch_ctrl;
    import ddp_fetch_pkg::*;

    localparam int PW = 38;
    localparam int AW = 5;
    localparam int SB = 37;
    localparam int LA = 31;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    int      n_cmp = 0;
    int      n_fail = 0;
    longint  cyc = 0;

    logic [PW-1:0] mem [32];
    logic [PW-1:0] rd_q = '0;

    int            exp_addr[$];
    int            got_addr[$];
    logic [PW-1:0] got_pkt[$];
    longint        got_cyc[$];
    int            done_cnt;
    bit            timed_out;

    packet_fetch_ctrl_if #(.PACKET_W(PW), .ADDR_W(AW)) bus ();

    packet_fetch_ctrl #(
        .PACKET_W  (PW),
        .ADDR_W    (AW),
        .LAST_ADDR (LA),
        .STOP_BIT  (SB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory: data shows up the cycle after the read strobe.
    always @(posedge clk) if (bus.mem_re) rd_q <= mem[bus.mem_addr];
    assign bus.mem_data = rd_q;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill_mem(input bit rand_stops);
        logic [63:0] r;
        for (int i = 0; i < 32; i++) begin
            r = {$urandom(), $urandom()};
            mem[i] = r[PW-1:0];
            mem[i][SB] = rand_stops ? ($urandom_range(0, 5) == 0) : (i == 3 || i == 9 || i == 25);
        end
    endtask

    // Program order: walk upward from the start address until a stop packet or the last address.
    function automatic void build_expected(input int start);
        int a;
        exp_addr.delete();
        a = start;
        for (int k = 0; k < 40; k++) begin
            exp_addr.push_back(a);
            if (mem[a][SB] || a == LA) break;
            a++;
        end
    endfunction

    task automatic start_run();
        bus.send_in = 1'b1;
        tick();
        bus.send_in = 1'b0;
    endtask

    task automatic load_idle(input int v);
        bus.pc_update = 1'b1;
        bus.pc_next   = AW'(v);
        tick();
        bus.pc_update = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !bus.packet_valid; i++) tick();
        n_cmp++;
        if (bus.packet_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wait_valid: valid=%0b, expected 1 within %0d cycles", bus.packet_valid, budget);
        end
    endtask

    // Records every accepted packet until the controller goes idle.
    task automatic collect(input int budget, input bit rand_ready);
        got_addr.delete();
        got_pkt.delete();
        got_cyc.delete();
        done_cnt  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            bus.packet_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.done) done_cnt++;
            if (bus.packet_valid && bus.packet_ready) begin
                got_addr.push_back(int'(bus.pc_out));
                got_pkt.push_back(bus.packet_out);
                got_cyc.push_back(cyc);
            end
            if (!bus.busy) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        bus.packet_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({bus.busy, bus.packet_valid, bus.mem_re, bus.done} !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: busy/valid/re/done=%b, expected 0000",
                     {bus.busy, bus.packet_valid, bus.mem_re, bus.done});
        end
        n_cmp++;
        if (bus.pc_out !== '0 || bus.mem_addr !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_pc: pc=%0d addr=%0d, expected 0", bus.pc_out, bus.mem_addr);
        end
        n_cmp++;
        if (bus.packet_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_packet: got %0h, expected 0", bus.packet_out);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release_busy: got %0b, expected 0", bus.busy);
        end
    endtask

    task automatic test_run_stop();
        build_expected(0);
        bus.packet_ready = 1'b1;
        start_run();
        n_cmp++;
        if ({bus.busy, bus.mem_re, bus.packet_valid} !== 3'b110 || bus.mem_addr !== AW'(0)) begin
            n_fail++;
            $display("[TB] FAIL req_cycle: busy/re/valid=%b addr=%0d, expected 110 addr 0",
                     {bus.busy, bus.mem_re, bus.packet_valid}, bus.mem_addr);
        end
        tick();
        n_cmp++;
        if ({bus.mem_re, bus.packet_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL cap_cycle: re/valid=%b, expected 00", {bus.mem_re, bus.packet_valid});
        end
        tick();
        n_cmp++;
        if (bus.packet_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL valid_latency: valid=%0b three cycles after edge, expected 1", bus.packet_valid);
        end
        collect(200, 1'b0);
        n_cmp++;
        if (timed_out || got_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("[TB] FAIL run_count: got %0d packets (timeout=%0b), expected %0d",
                     got_addr.size(), timed_out, exp_addr.size());
        end
        for (int k = 0; k < exp_addr.size(); k++) begin
            n_cmp++;
            if (k >= got_addr.size() || got_addr[k] !== exp_addr[k] || got_pkt[k] !== mem[exp_addr[k]]) begin
                n_fail++;
                $display("[TB] FAIL run_packet[%0d]: got addr %0d data %0h, expected addr %0d data %0h", k,
                         (k < got_addr.size()) ? got_addr[k] : -1,
                         (k < got_pkt.size()) ? got_pkt[k] : '0, exp_addr[k], mem[exp_addr[k]]);
            end
        end
        for (int k = 1; k < got_cyc.size(); k++) begin
            n_cmp++;
            if (got_cyc[k] - got_cyc[k-1] != 3) begin
                n_fail++;
                $display("[TB] FAIL throughput[%0d]: got %0d cycles between packets, expected 3",
                         k, got_cyc[k] - got_cyc[k-1]);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || bus.pc_out !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL run_end: done=%0d pc=%0d busy=%0b, expected 1 0 0", done_cnt, bus.pc_out, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL done_pulse: got %0b one cycle later, expected 0", bus.done);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] pkt0;
        logic [AW-1:0] pc0;
        bus.packet_ready = 1'b0;
        start_run();
        wait_valid(10);
        pkt0 = bus.packet_out;
        pc0  = bus.pc_out;
        n_cmp++;
        if (pc0 !== AW'(0) || pkt0 !== mem[0]) begin
            n_fail++;
            $display("[TB] FAIL bp_first: got pc %0d data %0h, expected pc 0 data %0h", pc0, pkt0, mem[0]);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (bus.packet_out !== mem[0] || bus.mem_re !== 1'b0 || bus.pc_out !== AW'(0) || bus.packet_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL bp_hold[%0d]: data %0h re %0b pc %0d valid %0b, expected %0h 0 0 1",
                         i, bus.packet_out, bus.mem_re, bus.pc_out, bus.packet_valid, mem[0]);
            end
        end
        bus.packet_ready = 1'b1;
        tick();
        bus.packet_ready = 1'b0;
        n_cmp++;
        if (bus.pc_out !== AW'(1) || bus.packet_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_release: pc %0d valid %0b, expected pc 1 valid 0", bus.pc_out, bus.packet_valid);
        end
        collect(200, 1'b0);
        n_cmp++;
        if (timed_out || done_cnt != 1 || got_addr.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL bp_finish: packets %0d done %0d timeout %0b, expected 3 1 0",
                     got_addr.size(), done_cnt, timed_out);
        end
    endtask

    task automatic test_load_busy();
        bus.packet_ready = 1'b1;
        start_run();
        tick();
        tick();
        tick();
        tick();
        // now in CAP of address 1
        bus.pc_update    = 1'b1;
        bus.pc_next      = AW'(20);
        bus.packet_ready = 1'b0;
        tick();
        bus.pc_update = 1'b0;
        n_cmp++;
        if (bus.pc_out !== AW'(1) || bus.packet_out !== mem[1]) begin
            n_fail++;
            $display("[TB] FAIL load_busy_hold: pc %0d data %0h, expected pc 1 data %0h", bus.pc_out, bus.packet_out, mem[1]);
        end
        bus.packet_ready = 1'b1;
        tick();
        bus.packet_ready = 1'b0;
        n_cmp++;
        if (bus.mem_addr !== AW'(20) || bus.mem_re !== 1'b1 || bus.pc_out !== AW'(20)) begin
            n_fail++;
            $display("[TB] FAIL load_busy_fetch20: addr %0d re %0b pc %0d, expected 20 1 20", bus.mem_addr, bus.mem_re, bus.pc_out);
        end
        tick();
        tick();
        bus.pc_update = 1'b1;
        bus.pc_next   = AW'(22);
        tick();
        bus.pc_next   = AW'(25);
        tick();
        bus.pc_update = 1'b0;
        n_cmp++;
        if (bus.pc_out !== AW'(20) || bus.packet_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL load_busy_pending: pc %0d valid %0b, expected 20 1", bus.pc_out, bus.packet_valid);
        end
        bus.packet_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.mem_addr !== AW'(25) || bus.mem_re !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL load_busy_last_wins: addr %0d re %0b, expected 25 1", bus.mem_addr, bus.mem_re);
        end
        collect(200, 1'b0);
        n_cmp++;
        if (timed_out || done_cnt != 1 || got_addr.size() != 1 || got_addr[0] != 25) begin
            n_fail++;
            $display("[TB] FAIL load_busy_end: packets %0d first %0d done %0d, expected 1 25 1",
                     got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : -1, done_cnt);
        end
    endtask

    task automatic test_load_handshake();
        bus.packet_ready = 1'b0;
        start_run();
        wait_valid(10);
        bus.pc_update = 1'b1;
        bus.pc_next   = AW'(20);
        tick();
        bus.pc_next      = AW'(9);
        bus.packet_ready = 1'b1;
        tick();
        bus.pc_update    = 1'b0;
        bus.packet_ready = 1'b0;
        n_cmp++;
        if (bus.mem_addr !== AW'(9) || bus.pc_out !== AW'(9) || bus.mem_re !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL load_handshake: addr %0d pc %0d re %0b, expected 9 9 1", bus.mem_addr, bus.pc_out, bus.mem_re);
        end
        collect(200, 1'b0);
        n_cmp++;
        if (timed_out || done_cnt != 1 || got_addr.size() != 1 || got_pkt[0] !== mem[9]) begin
            n_fail++;
            $display("[TB] FAIL load_handshake_end: packets %0d done %0d, expected 1 packet of addr 9 and 1 done",
                     got_addr.size(), done_cnt);
        end
    endtask

    task automatic test_end_by_addr();
        load_idle(30);
        n_cmp++;
        if (bus.pc_out !== AW'(30) || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_load: pc %0d busy %0b, expected 30 0", bus.pc_out, bus.busy);
        end
        bus.packet_ready = 1'b1;
        start_run();
        tick();
        bus.send_in = 1'b1;
        tick();
        bus.send_in = 1'b0;
        collect(200, 1'b0);
        n_cmp++;
        if (timed_out || got_addr.size() != 2 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL end_addr_count: packets %0d done %0d, expected 2 1", got_addr.size(), done_cnt);
        end else begin
            n_cmp++;
            if (got_addr[0] != 30 || got_addr[1] != 31 || got_pkt[1] !== mem[31]) begin
                n_fail++;
                $display("[TB] FAIL end_addr_order: got %0d,%0d, expected 30,31", got_addr[0], got_addr[1]);
            end
        end
        repeat (4) tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.mem_re !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ignored_send: busy %0b re %0b, expected 0 0", bus.busy, bus.mem_re);
        end
    endtask

    task automatic test_async_reset();
        load_idle(5);
        bus.packet_ready = 1'b0;
        start_run();
        wait_valid(10);
        bus.pc_update = 1'b1;
        bus.pc_next   = AW'(20);
        tick();
        bus.pc_update = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.packet_valid, bus.mem_re, bus.done} !== 4'b0 || bus.pc_out !== '0
            || bus.mem_addr !== '0 || bus.packet_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: busy/valid/re/done=%b pc %0d addr %0d data %0h, expected all 0",
                     {bus.busy, bus.packet_valid, bus.mem_re, bus.done}, bus.pc_out, bus.mem_addr, bus.packet_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset_nodone: done %0b busy %0b, expected 0 0", bus.done, bus.busy);
        end
        build_expected(0);
        bus.packet_ready = 1'b1;
        start_run();
        n_cmp++;
        if (bus.mem_addr !== AW'(0) || bus.mem_re !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_fetch: addr %0d re %0b, expected 0 1", bus.mem_addr, bus.mem_re);
        end
        collect(200, 1'b0);
        n_cmp++;
        if (timed_out || got_addr.size() != exp_addr.size() || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_run: packets %0d done %0d, expected %0d 1", got_addr.size(), done_cnt, exp_addr.size());
        end else begin
            for (int k = 0; k < exp_addr.size(); k++) begin
                n_cmp++;
                if (got_addr[k] != exp_addr[k]) begin
                    n_fail++;
                    $display("[TB] FAIL post_reset_addr[%0d]: got %0d, expected %0d", k, got_addr[k], exp_addr[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int start;
        for (int it = 0; it < 8; it++) begin
            fill_mem(1'b1);
            start = $urandom_range(0, 31);
            load_idle(start);
            build_expected(start);
            start_run();
            collect(2000, 1'b1);
            n_cmp++;
            if (timed_out || got_addr.size() != exp_addr.size()) begin
                n_fail++;
                $display("[TB] FAIL rand_count[%0d]: got %0d packets (timeout=%0b), expected %0d from start %0d",
                         it, got_addr.size(), timed_out, exp_addr.size(), start);
            end
            for (int k = 0; k < exp_addr.size(); k++) begin
                n_cmp++;
                if (k >= got_addr.size() || got_addr[k] !== exp_addr[k] || got_pkt[k] !== mem[exp_addr[k]]) begin
                    n_fail++;
                    $display("[TB] FAIL rand_packet[%0d][%0d]: got addr %0d, expected addr %0d data %0h", it, k,
                             (k < got_addr.size()) ? got_addr[k] : -1, exp_addr[k], mem[exp_addr[k]]);
                end
            end
            n_cmp++;
            if (done_cnt != 1 || bus.pc_out !== '0) begin
                n_fail++;
                $display("[TB] FAIL rand_end[%0d]: done %0d pc %0d, expected 1 0", it, done_cnt, bus.pc_out);
            end
            tick();
        end
    endtask

    initial begin
        bus.send_in      = 1'b0;
        bus.pc_update    = 1'b0;
        bus.pc_next      = '0;
        bus.packet_ready = 1'b0;
        fill_mem(1'b0);
        test_reset();
        test_run_stop();
        test_backpressure();
        test_load_busy();
        test_load_handshake();
        test_end_by_addr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
